// File: rtl/npu_instr_fetch_if.sv
// Host-load and NPU-fetch signals of the instruction fetch stage.
// The master is the host/NPU side and the slave is the fetch block.
interface npu_instr_fetch_if #(
    parameter int INSTR_WIDTH = 47,
    parameter int AWIDTH      = 9
);
    // Handshake rules:
    // - A host write commits on a rising edge where load_valid && load_ready.
    // - load_valid while load_ready is low is dropped and never retried.
    // - get_instr is a one-shot request with no ready.
    // - A served request returns instr_valid one cycle later.
    logic                   load_valid;
    logic                   load_ready;
    logic [AWIDTH-1:0]      load_addr;
    logic [INSTR_WIDTH-1:0] load_instr;
    logic                   get_instr;
    logic [AWIDTH-1:0]      get_instr_addr;
    logic [INSTR_WIDTH-1:0] instruction;
    logic                   instr_valid;

    modport master (
        output load_valid, load_addr, load_instr, get_instr, get_instr_addr,
        input  load_ready, instruction, instr_valid
    );

    modport slave (
        input  load_valid, load_addr, load_instr, get_instr, get_instr_addr,
        output load_ready, instruction, instr_valid
    );
endinterface

// File: rtl/npu_instr_fetch.sv
// Instruction memory and fetch stage feeding the NPU.
// It serves preloaded words with 1-cycle latency, detects END_CHAIN, flags OOB fetches and counts fetches.
module npu_instr_fetch #(
    parameter int INSTR_WIDTH = 47,
    parameter int AWIDTH      = 9,
    parameter int END_OPCODE  = 12,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    npu_instr_fetch_if.slave     bus,
    input  logic                 start,
    input  logic [AWIDTH:0]      prog_len,
    output logic                 busy,
    output logic                 done,
    output logic                 err_oob,
    output logic                 err_start,
    output logic [CNT_WIDTH-1:0] fetch_count,
    output logic [1:0]           state_dbg
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0]             END_OP   = 4'(END_OPCODE);
    localparam logic [INSTR_WIDTH-1:0] END_WORD = {END_OP, {(INSTR_WIDTH-4){1'b0}}};
    localparam logic [AWIDTH:0]        MAX_LEN  = {1'b1, {AWIDTH{1'b0}}};

    state_t                 state_q, state_d;
    logic [INSTR_WIDTH-1:0] mem [2**AWIDTH];
    logic [AWIDTH:0]        prog_len_q;
    logic [AWIDTH:0]        prog_len_clamped;
    logic                   wr_en;
    logic                   serve;
    logic                   serve_run;
    logic                   in_range;
    logic                   fetch_end;
    logic                   start_ok;
    logic                   start_bad;
    logic [INSTR_WIDTH-1:0] fetch_word;

    assign bus.load_ready = (state_q != S_RUN);
    assign busy           = (state_q == S_RUN);
    assign done           = (state_q == S_DONE);
    assign state_dbg      = state_q;

    always_comb begin
        wr_en            = bus.load_valid && (state_q != S_RUN);
        serve            = bus.get_instr && (state_q == S_RUN || state_q == S_DONE);
        serve_run        = bus.get_instr && (state_q == S_RUN);
        in_range         = ({1'b0, bus.get_instr_addr} < prog_len_q);
        start_ok         = start && (state_q == S_LOAD) && (prog_len != '0);
        start_bad        = start && !start_ok;
        prog_len_clamped = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
        fetch_word       = END_WORD;
        // DONE always answers with END_CHAIN, so only RUN reads the memory.
        if (state_q == S_RUN && in_range) begin
            fetch_word = mem[bus.get_instr_addr];
        end
        fetch_end = serve_run &&
                    (!in_range || fetch_word[INSTR_WIDTH-1 -: 4] == END_OP);

        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.load_valid) state_d = S_LOAD;
            S_LOAD:  if (start_ok)       state_d = S_RUN;
            S_RUN:   if (fetch_end)      state_d = S_DONE;
            S_DONE:  if (bus.load_valid) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            prog_len_q      <= '0;
            bus.instruction <= '0;
            bus.instr_valid <= 1'b0;
            err_oob         <= 1'b0;
            err_start       <= 1'b0;
            fetch_count     <= '0;
        end else begin
            state_q         <= state_d;
            bus.instr_valid <= serve;
            if (serve) begin
                bus.instruction <= fetch_word;
            end
            // A start is accepted only in LOAD, so it never coincides with a RUN fetch.
            if (start_ok) begin
                prog_len_q  <= prog_len_clamped;
                fetch_count <= '0;
                err_oob     <= 1'b0;
            end else if (serve_run && fetch_count != '1) begin
                fetch_count <= fetch_count + CNT_WIDTH'(1);
            end
            if (serve_run && !in_range) begin
                err_oob <= 1'b1;
            end
            if (start_bad) begin
                err_start <= 1'b1;
            end
        end
    end

    // The program survives reset, so the memory has no reset term.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[bus.load_addr] <= bus.load_instr;
        end
    end
endmodule
